// File: rtl/shift_rows_pipe_if.sv
// Stream bundle for shift_rows_pipe.
//   in_valid/in_ready/in_mode/in_tag/in_data : upstream handshake and state
//   out_valid/out_ready/out_tag/out_data     : downstream handshake and state
//   count                                    : buffer occupancy, 0..2
// master drives in_* and out_ready (the producer/consumer side).
// slave is the shift_rows_pipe side.
interface shift_rows_pipe_if #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic                in_mode;
  logic [TAG_W-1:0]    in_tag;
  logic [32*NB-1:0]    in_data;
  logic                out_valid;
  logic                out_ready;
  logic [TAG_W-1:0]    out_tag;
  logic [32*NB-1:0]    out_data;
  logic [1:0]          count;

  modport master (
    output in_valid, in_mode, in_tag, in_data, out_ready,
    input  in_ready, out_valid, out_tag, out_data, count
  );

  modport slave (
    input  in_valid, in_mode, in_tag, in_data, out_ready,
    output in_ready, out_valid, out_tag, out_data, count
  );
endinterface

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage for Rijndael states of NB columns.
// The permutation is applied combinationally on the input; only the permuted
// state and its tag are stored in a 2-entry FIFO, so in_ready depends on
// registered occupancy only.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : shift_rows_pipe_if.slave (in_* upstream, out_* downstream, count)
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  shift_rows_pipe_if.slave  bus
);
  localparam int unsigned W = 32 * NB;

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (TAG_W < 1) begin : g_bad_tag
      $error("shift_rows_pipe: TAG_W must be >= 1");
    end
  endgenerate

  // Row rotation amount; NB=8 uses the wider Rijndael offsets.
  function automatic int unsigned row_off(input int unsigned r);
    case (r)
      1:       row_off = 1;
      2:       row_off = (NB == 8) ? 3 : 2;
      3:       row_off = (NB == 8) ? 4 : 3;
      default: row_off = 0;
    endcase
  endfunction

  // Source column feeding output column c of row r.
  function automatic int unsigned src_col(input int unsigned r,
                                          input int unsigned c,
                                          input logic        inv);
    if (inv) src_col = (c + NB - row_off(r)) % NB;
    else     src_col = (c + row_off(r)) % NB;
  endfunction

  logic [W-1:0]     w_perm;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_emit;

  logic [W-1:0]     r_mem [0:1];
  logic [TAG_W-1:0] r_tag [0:1];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  always_comb begin
    w_perm = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < NB; c++) begin
        w_perm[W-1-8*(4*c+r) -: 8] =
          bus.in_data[W-1-8*(4*src_col(r, c, bus.in_mode)+r) -: 8];
      end
    end
  end

  assign w_in_ready  = (r_count != 2'd2);
  assign w_out_valid = (r_count != 2'd0);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_emit      = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
        r_tag[i] <= '0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_accept) begin
        r_mem[r_wptr] <= w_perm;
        r_tag[r_wptr] <= bus.in_tag;
        r_wptr        <= ~r_wptr;
      end
      if (w_emit) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_accept, w_emit})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_mem[r_rptr];
  assign bus.out_tag   = r_tag[r_rptr];
  assign bus.count     = r_count;
endmodule
